// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: request/response bundle for fifo_sync_param
// master: drives wr_en, rd_en, d_in; observes data, count, flags and pulses
// slave : the FIFO side, drives d_out, data_count, status flags, ack/err pulses
interface fifo_sync_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic                     wr_en;
    logic                     rd_en;
    logic [WIDTH-1:0]         d_in;
    logic [WIDTH-1:0]         d_out;
    logic [$clog2(DEPTH):0]   data_count;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic                     wr_ack;
    logic                     wr_err;
    logic                     rd_ack;
    logic                     rd_err;
    modport master (
        output wr_en, rd_en, d_in,
        input  d_out, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err
    );
    modport slave (
        input  wr_en, rd_en, d_in,
        output d_out, data_count, full, empty, almost_full, almost_empty,
               wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered data, count, status flags and ack/err pulses
// clk, reset    : clock and synchronous active-high reset
// fifo (slave)  : wr_en/d_in write side, rd_en/d_out read side, data_count, full/empty,
//                 almost_full/almost_empty, wr_ack/wr_err/rd_ack/rd_err one-cycle pulses
module fifo_sync_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input logic                clk,
    input logic                reset,
    fifo_sync_param_if.slave   fifo
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WRITE  = 3'd1;
    localparam logic [2:0] READ   = 3'd2;
    localparam logic [2:0] WR_RD  = 3'd3;
    localparam logic [2:0] WR_ERR = 3'd4;
    localparam logic [2:0] RD_ERR = 3'd5;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] d_out_q;
    logic [2:0]       state_q, state_d;
    logic             rd_err_wr_q;
    logic             full_q, empty_q, af_q, ae_q;
    logic             do_wr, do_rd, cnt_zero, cnt_full;
    always_comb begin
        cnt_zero = count_q == '0;
        cnt_full = count_q == CNT_W'(DEPTH);
        do_rd    = fifo.rd_en && !cnt_zero;
        // when full, a simultaneous read frees the slot the write lands in
        do_wr    = fifo.wr_en && (!cnt_full || fifo.rd_en);
        state_d  = (fifo.wr_en && fifo.rd_en) ? (cnt_zero ? RD_ERR : WR_RD) :
                   fifo.wr_en ? (cnt_full ? WR_ERR : WRITE) :
                   fifo.rd_en ? (cnt_zero ? RD_ERR : READ) : IDLE;
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
    always_ff @(posedge clk) begin
        if (!reset && do_wr) mem_q[head_q] <= fifo.d_in;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_err_wr_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            d_out_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            // RD_ERR also covers write+read on empty, where the write is still accepted
            rd_err_wr_q <= state_d == RD_ERR && fifo.wr_en;
            if (do_wr) head_q <= head_q + AW'(1);
            if (do_rd) begin
                tail_q  <= tail_q + AW'(1);
                d_out_q <= mem_q[tail_q];
            end
            count_q     <= count_d;
            full_q      <= count_d == CNT_W'(DEPTH);
            empty_q     <= count_d == '0;
            af_q        <= count_d >= CNT_W'(AF_LEVEL);
            ae_q        <= count_d <= CNT_W'(AE_LEVEL);
        end
    end
    assign fifo.d_out        = d_out_q;
    assign fifo.data_count   = count_q;
    assign fifo.full         = full_q;
    assign fifo.empty        = empty_q;
    assign fifo.almost_full  = af_q;
    assign fifo.almost_empty = ae_q;
    assign fifo.wr_ack       = state_q == WRITE || state_q == WR_RD || rd_err_wr_q;
    assign fifo.wr_err       = state_q == WR_ERR;
    assign fifo.rd_ack       = state_q == READ || state_q == WR_RD;
    assign fifo.rd_err       = state_q == RD_ERR;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: scoreboard bench for fifo_sync_param against a queue-based model
module tb_fifo_sync_param;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;
    typedef struct {
        logic [WIDTH-1:0] dout;
        int               cnt;
        bit               full, empty, af, ae, wa, we, ra, re;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_dout = '0;
    int passed = 0;
    int total  = 0;
    bit done   = 1'b0;
    fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    fifo_sync_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk   (clk),
        .reset (reset),
        .fifo  (bus)
    );
    always #5 clk = ~clk;
    function automatic void chk(input string n, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    endfunction
    task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit rs);
        exp_t e;
        bit ok_r, ok_w;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.d_in  = d;
        reset     = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_dout = '0;
            ok_r = 1'b0;
            ok_w = 1'b0;
        end else begin
            ok_r = r && mq.size() > 0;
            ok_w = w && (mq.size() < DEPTH || r);
            if (ok_r) m_dout = mq.pop_front();
            if (ok_w) mq.push_back(d);
        end
        e.dout  = m_dout;
        e.cnt   = mq.size();
        e.full  = mq.size() == DEPTH;
        e.empty = mq.size() == 0;
        e.af    = mq.size() >= AF;
        e.ae    = mq.size() <= AE;
        e.wa    = ok_w;
        e.we    = !rs && w && !ok_w;
        e.ra    = ok_r;
        e.re    = !rs && r && !ok_r;
        sb.push_back(e);
        #1;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("d_out", bus.d_out, e.dout);
                chk("data_count", WIDTH'(bus.data_count), WIDTH'(e.cnt));
                chk("full", WIDTH'(bus.full), WIDTH'(e.full));
                chk("empty", WIDTH'(bus.empty), WIDTH'(e.empty));
                chk("almost_full", WIDTH'(bus.almost_full), WIDTH'(e.af));
                chk("almost_empty", WIDTH'(bus.almost_empty), WIDTH'(e.ae));
                chk("wr_ack", WIDTH'(bus.wr_ack), WIDTH'(e.wa));
                chk("wr_err", WIDTH'(bus.wr_err), WIDTH'(e.we));
                chk("rd_ack", WIDTH'(bus.rd_ack), WIDTH'(e.ra));
                chk("rd_err", WIDTH'(bus.rd_err), WIDTH'(e.re));
            end else if (!done && (bus.wr_ack || bus.wr_err || bus.rd_ack || bus.rd_err)) begin
                chk("spurious_pulse", WIDTH'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), '0);
            end
        end
    end
    initial begin : driver
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.d_in  = '0;
        reset     = 1'b1;
        repeat (2) step(0, 0, '0, 1);
        for (int i = 1; i <= 8; i++) step(1, 0, WIDTH'(i * 'h11), 0);
        step(1, 0, 'hFF, 0);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0);
        step(0, 1, '0, 0);
        step(1, 1, 'hA5, 0);
        step(0, 1, '0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, $urandom, 0);
        for (int i = 0; i < 12; i++) step(1, 1, $urandom, 0);
        for (int i = 0; i < 4; i++) step(1, 0, $urandom, 0);
        step(1, 1, 'h5A5A, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, $urandom, 0);
        step(1, 0, 'hDEAD, 1);
        step(0, 1, '0, 0);
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = i / 500;
            step(($urandom % 4) < ((mode % 2) ? 3 : 1), ($urandom % 4) < ((mode % 2) ? 1 : 3),
                 $urandom, ($urandom % 150) == 0);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) chk("scoreboard_drain", WIDTH'(sb.size()), '0);
        done = 1'b1;
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
